// File: rtl/pixel_layer_arbiter_pkg.sv
// Shared definitions for the pixel layer arbiter.
// Holds the configuration register addresses, the configuration FSM state
// encoding, the reset defaults of the configuration registers and a helper
// that maps a programmed blink period to its last frame-counter value.
package pixel_layer_arbiter_pkg;

    localparam logic [1:0] ADDR_ENABLE = 2'd0;
    localparam logic [1:0] ADDR_BLINK  = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_BG     = 2'd3;

    typedef enum logic [0:0] {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

    localparam logic [7:0] RST_ENABLE  = 8'hFF;  // all layers enabled
    localparam logic [7:0] RST_BLINK   = 8'h00;  // no layer blinks
    localparam logic [7:0] RST_BG      = 8'h00;  // black background
    localparam int         RST_PERIOD  = 30;     // frames per blink phase

    // A period of 0 behaves like 1, so the counter wraps every frame.
    function automatic logic [7:0] last_frame(input logic [7:0] period);
        return (period == 8'd0) ? 8'd0 : period - 8'd1;
    endfunction

endpackage

// File: rtl/pixel_layer_arbiter_blink_timer.sv
// Frame counter and blink phase generator.
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   frame_start_i     one-cycle pulse per frame; advances the counter
//   period_load_i     a new period is being committed; restarts the count
//   period_i          active blink period in frames (0 behaves like 1)
//   blink_phase_o     toggles every period frames
module pixel_layer_arbiter_blink_timer
    import pixel_layer_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_start_i,
    input  logic       period_load_i,
    input  logic [7:0] period_i,
    output logic       blink_phase_o
);

    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        // A period change restarts the count but leaves the phase alone,
        // even when the same frame_start would otherwise have wrapped.
        if (period_load_i) begin
            frame_cnt_d = 8'd0;
        end else if (frame_start_i) begin
            if (frame_cnt_q == last_frame(period_i)) begin
                frame_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Two-stage pixel layer arbiter with blink support.
// Stage 1 registers the per-layer visibility (active & enabled & not blanked
// by the blink phase) together with colours, coordinates and background;
// stage 2 registers the lowest-index visible layer's colour, or the
// background when no layer is visible.
// Configuration writes land in a shadow register and are committed to the
// active register on the next frame_start, so a frame never changes mid-way.
// Handshake: a write is transferred on a clock edge where cfg_wr and
// cfg_ready are both 1; cfg_ready is 0 while a write waits for its commit.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pix_valid, x, y            incoming pixel and its coordinates
//   frame_start                start-of-frame pulse (commit and blink tick)
//   layer_active, layer_color  per-layer flags and packed colours
//   cfg_wr, cfg_addr, cfg_data configuration write request
//   cfg_ready                  configuration write can be accepted
//   color_out, color_valid     arbitrated colour, 2 cycles after pix_valid
//   x_out, y_out               coordinates aligned with color_out
//   layer_sel, any_active      winning layer index, any layer visible
module pixel_layer_arbiter
    import pixel_layer_arbiter_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 3,
    parameter int DEF_PERIOD = RST_PERIOD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_valid,
    input  logic [7:0]                    x,
    input  logic [6:0]                    y,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_active,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic                          cfg_wr,
    input  logic [1:0]                    cfg_addr,
    input  logic [7:0]                    cfg_data,
    output logic                          cfg_ready,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          color_valid,
    output logic [7:0]                    x_out,
    output logic [6:0]                    y_out,
    output logic [1:0]                    layer_sel,
    output logic                          any_active
);

    // Configuration FSM and registers
    cfg_state_t            state_q;
    logic [1:0]            sh_addr_q;
    logic [7:0]            sh_data_q;
    logic [NUM_LAYERS-1:0] enable_q;
    logic [NUM_LAYERS-1:0] blink_q;
    logic [7:0]            period_q;
    logic [COLOR_W-1:0]    bg_q;
    logic                  commit;
    logic                  period_load;
    logic                  blink_phase;

    assign commit      = (state_q == CFG_PENDING) && frame_start;
    assign period_load = commit && (sh_addr_q == ADDR_PERIOD);

    // A write accepted in IDLE during a frame_start only reaches PENDING at
    // that edge, so it naturally waits for the following frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CFG_IDLE;
            cfg_ready <= 1'b1;
            sh_addr_q <= 2'd0;
            sh_data_q <= 8'd0;
            enable_q  <= RST_ENABLE[NUM_LAYERS-1:0];
            blink_q   <= RST_BLINK[NUM_LAYERS-1:0];
            period_q  <= DEF_PERIOD[7:0];
            bg_q      <= RST_BG[COLOR_W-1:0];
        end else begin
            case (state_q)
                CFG_IDLE: begin
                    if (cfg_wr) begin
                        sh_addr_q <= cfg_addr;
                        sh_data_q <= cfg_data;
                        state_q   <= CFG_PENDING;
                        cfg_ready <= 1'b0;
                    end
                end
                CFG_PENDING: begin
                    if (frame_start) begin
                        case (sh_addr_q)
                            ADDR_ENABLE: enable_q <= sh_data_q[NUM_LAYERS-1:0];
                            ADDR_BLINK:  blink_q  <= sh_data_q[NUM_LAYERS-1:0];
                            ADDR_PERIOD: period_q <= sh_data_q;
                            default:     bg_q     <= sh_data_q[COLOR_W-1:0];
                        endcase
                        state_q   <= CFG_IDLE;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= CFG_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    pixel_layer_arbiter_blink_timer u_blink_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .frame_start_i (frame_start),
        .period_load_i (period_load),
        .period_i      (period_q),
        .blink_phase_o (blink_phase)
    );

    // Stage 1: visibility and captured pixel data
    logic                          s1_valid_q;
    logic [NUM_LAYERS-1:0]         s1_vis_q;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_color_q;
    logic [7:0]                    s1_x_q;
    logic [6:0]                    s1_y_q;
    logic [COLOR_W-1:0]            s1_bg_q;
    logic [NUM_LAYERS-1:0]         vis_d;

    assign vis_d = layer_active & enable_q & ~(blink_q & {NUM_LAYERS{blink_phase}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_vis_q   <= '0;
            s1_color_q <= '0;
            s1_x_q     <= 8'd0;
            s1_y_q     <= 7'd0;
            s1_bg_q    <= '0;
        end else begin
            s1_valid_q <= pix_valid;
            s1_vis_q   <= vis_d;
            s1_color_q <= layer_color;
            s1_x_q     <= x;
            s1_y_q     <= y;
            s1_bg_q    <= bg_q;
        end
    end

    // Stage 2: fixed-priority select, lowest index wins
    logic               win_found;
    logic [1:0]         win_idx;
    logic [COLOR_W-1:0] win_color;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        win_color = s1_bg_q;
        // Scan from the top so the last hit is the lowest visible index.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_vis_q[i]) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
                win_color = s1_color_q[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_valid <= 1'b0;
            color_out   <= '0;
            layer_sel   <= 2'd0;
            any_active  <= 1'b0;
            x_out       <= 8'd0;
            y_out       <= 7'd0;
        end else begin
            color_valid <= s1_valid_q;
            x_out       <= s1_x_q;
            y_out       <= s1_y_q;
            if (s1_valid_q) begin
                color_out  <= win_color;
                layer_sel  <= win_idx;
                any_active <= win_found;
            end else begin
                color_out  <= '0;
                layer_sel  <= 2'd0;
                any_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Directed bench for pixel_layer_arbiter: priority, enable masking,
// background, configuration handshake, blink timing and reset behaviour.
module tb_pixel_layer_arbiter;

    localparam int NL = 4;
    localparam int CW = 3;
    // L3=111, L2=100, L1=010, L0=001
    localparam logic [NL*CW-1:0] COLS = {3'b111, 3'b100, 3'b010, 3'b001};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pix_valid = 1'b0;
    logic [7:0]        x = 8'd0;
    logic [6:0]        y = 7'd0;
    logic              frame_start = 1'b0;
    logic [NL-1:0]     layer_active = '0;
    logic [NL*CW-1:0]  layer_color = '0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_addr = 2'd0;
    logic [7:0]        cfg_data = 8'd0;
    logic              cfg_ready;
    logic [CW-1:0]     color_out;
    logic              color_valid;
    logic [7:0]        x_out;
    logic [6:0]        y_out;
    logic [1:0]        layer_sel;
    logic              any_active;

    int n_assert = 0;
    int n_fail   = 0;

    pixel_layer_arbiter #(.NUM_LAYERS(NL), .COLOR_W(CW), .DEF_PERIOD(30)) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .layer_active (layer_active),
        .layer_color  (layer_color),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .color_out    (color_out),
        .color_valid  (color_valid),
        .x_out        (x_out),
        .y_out        (y_out),
        .layer_sel    (layer_sel),
        .any_active   (any_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel and advance until it reaches the outputs.
    task automatic send_pix(input logic [NL-1:0] act, input logic [7:0] px, input logic [6:0] py);
        pix_valid    = 1'b1;
        layer_active = act;
        layer_color  = COLS;
        x            = px;
        y            = py;
        step();
        pix_valid    = 1'b0;
        layer_active = '0;
        step();
    endtask

    task automatic chk_pix(input string tag, input logic [CW-1:0] c, input logic [1:0] sel,
                           input logic any);
        chk({tag, "_valid"}, 32'(color_valid), 32'd1);
        chk({tag, "_color"}, 32'(color_out), 32'(c));
        chk({tag, "_sel"},   32'(layer_sel), 32'(sel));
        chk({tag, "_any"},   32'(any_active), 32'(any));
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_valid", 32'(color_valid), 32'd0);
        chk("rst_color", 32'(color_out), 32'd0);
        chk("rst_sel",   32'(layer_sel), 32'd0);
        chk("rst_any",   32'(any_active), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;
        step();

        // Priority with latency check: L0 and L2 active, L0 wins
        pix_valid    = 1'b1;
        layer_active = 4'b0101;
        layer_color  = COLS;
        x            = 8'h12;
        y            = 7'h34;
        step();
        pix_valid    = 1'b0;
        layer_active = '0;
        chk("lat1_valid", 32'(color_valid), 32'd0);
        step();
        chk_pix("prio", 3'b001, 2'd0, 1'b1);
        chk("prio_x", 32'(x_out), 32'h12);
        chk("prio_y", 32'(y_out), 32'h34);
        step();
        chk("inv_valid", 32'(color_valid), 32'd0);
        chk("inv_color", 32'(color_out), 32'd0);
        chk("inv_any",   32'(any_active), 32'd0);

        // Enable mask 1110: pending until frame_start
        cfg_write(2'd0, 8'h0E);
        chk("mask_ready_pend", 32'(cfg_ready), 32'd0);
        send_pix(4'b0101, 8'h20, 7'h01);
        chk_pix("mask_before", 3'b001, 2'd0, 1'b1);
        frame();
        chk("mask_ready_idle", 32'(cfg_ready), 32'd1);
        send_pix(4'b0101, 8'h21, 7'h02);
        chk_pix("mask_after", 3'b100, 2'd2, 1'b1);
        chk("mask_x", 32'(x_out), 32'h21);

        // Background 101 with cfg_wr held: accepted once, no change yet
        cfg_wr   = 1'b1;
        cfg_addr = 2'd3;
        cfg_data = 8'h05;
        step();
        step();
        step();
        chk("hold_ready", 32'(cfg_ready), 32'd0);
        cfg_wr = 1'b0;
        send_pix(4'b0000, 8'h30, 7'h03);
        chk_pix("bg_before", 3'b000, 2'd0, 1'b0);
        frame();
        send_pix(4'b0000, 8'h31, 7'h04);
        chk_pix("bg_after", 3'b101, 2'd0, 1'b0);

        // Write accepted in a frame_start cycle commits on the next one
        cfg_wr      = 1'b1;
        cfg_addr    = 2'd0;
        cfg_data    = 8'h0F;
        frame_start = 1'b1;
        step();
        cfg_wr      = 1'b0;
        frame_start = 1'b0;
        chk("simul_ready", 32'(cfg_ready), 32'd0);
        send_pix(4'b0101, 8'h40, 7'h05);
        chk_pix("simul_before", 3'b100, 2'd2, 1'b1);
        frame();
        send_pix(4'b0101, 8'h41, 7'h06);
        chk_pix("simul_after", 3'b001, 2'd0, 1'b1);

        // Blink: mask 0001, period 2 (commit restarts the counter at 0)
        cfg_write(2'd1, 8'h01);
        frame();
        cfg_write(2'd2, 8'h02);
        frame();
        send_pix(4'b0001, 8'h50, 7'h07);
        chk_pix("blink_f0", 3'b001, 2'd0, 1'b1);
        frame();
        send_pix(4'b0001, 8'h51, 7'h08);
        chk_pix("blink_f1", 3'b001, 2'd0, 1'b1);
        frame();
        send_pix(4'b0001, 8'h52, 7'h09);
        chk_pix("blink_f2", 3'b101, 2'd0, 1'b0);
        frame();
        send_pix(4'b0001, 8'h53, 7'h0A);
        chk_pix("blink_f3", 3'b101, 2'd0, 1'b0);
        frame();
        send_pix(4'b0001, 8'h54, 7'h0B);
        chk_pix("blink_f4", 3'b001, 2'd0, 1'b1);
        frame();
        send_pix(4'b0001, 8'h55, 7'h0C);
        chk_pix("blink_f5", 3'b001, 2'd0, 1'b1);

        // Period 0 behaves as 1: phase toggles every frame
        cfg_write(2'd2, 8'h00);
        frame();
        send_pix(4'b0001, 8'h60, 7'h0D);
        chk_pix("p0_f0", 3'b001, 2'd0, 1'b1);
        frame();
        send_pix(4'b0001, 8'h61, 7'h0E);
        chk_pix("p0_f1", 3'b101, 2'd0, 1'b0);
        frame();
        send_pix(4'b0001, 8'h62, 7'h0F);
        chk_pix("p0_f2", 3'b001, 2'd0, 1'b1);

        // Reset mid-PENDING and mid-stream
        cfg_write(2'd3, 8'h02);
        chk("rst2_pend", 32'(cfg_ready), 32'd0);
        pix_valid    = 1'b1;
        layer_active = 4'b0001;
        layer_color  = COLS;
        x            = 8'h70;
        y            = 7'h10;
        step();
        step();
        chk("stream_valid", 32'(color_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst2_valid", 32'(color_valid), 32'd0);
        chk("rst2_color", 32'(color_out), 32'd0);
        chk("rst2_any",   32'(any_active), 32'd0);
        chk("rst2_x",     32'(x_out), 32'd0);
        chk("rst2_ready", 32'(cfg_ready), 32'd1);
        pix_valid    = 1'b0;
        layer_active = '0;
        step();
        reset = 1'b0;
        step();
        frame();
        chk("rst2_ready_after", 32'(cfg_ready), 32'd1);
        send_pix(4'b0000, 8'h71, 7'h11);
        chk_pix("rst2_no_shadow", 3'b000, 2'd0, 1'b0);
        send_pix(4'b1010, 8'h72, 7'h12);
        chk_pix("rst2_enable_all", 3'b010, 2'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_layer_arbiter.md
PIXEL_LAYER_ARBITER -- requirements
Module: pixel_layer_arbiter

Interface
REQ-001 Parameter NUM_LAYERS, 4: number of drawing-object layers; layer 0 has the highest priority.
REQ-002 Parameter COLOR_W, 3: width of one layer colour.
REQ-003 Parameter DEF_PERIOD, 30: reset value of the blink period, in frames.
REQ-004 Clocking: one clock; reset is asynchronous and active-high (ports clk and reset).
REQ-005 clk  in  1  pixel clock; all state on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pix_valid  in  1  x/y/layer inputs valid this cycle.
REQ-008 x  in  8  pixel column; passed through the pipeline.
REQ-009 y  in  7  pixel row; passed through the pipeline.
REQ-010 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-011 layer_active  in  NUM_LAYERS  per-layer object-active flags.
REQ-012 layer_color  in  NUM_LAYERS*COLOR_W  per-layer colours; layer i occupies bits [3i+2:3i].
REQ-013 cfg_wr  in  1  configuration write request, held until accepted.
REQ-014 cfg_addr  in  2  configuration register select.
REQ-015 cfg_data  in  8  configuration write data.
REQ-016 cfg_ready  out  1  arbiter can accept a configuration write.
REQ-017 color_out  out  COLOR_W  arbitrated pixel colour.
REQ-018 color_valid  out  1  color_out, x_out and y_out valid.
REQ-019 x_out  out  8  x delayed to align with color_out.
REQ-020 y_out  out  7  y delayed to align with color_out.
REQ-021 layer_sel  out  2  index of the winning layer.
REQ-022 any_active  out  1  at least one visible layer is active.

Function
REQ-023 Configuration registers:
- addr 0: enable mask, data[3:0].
- addr 1: blink mask, data[3:0].
- addr 2: blink period in frames, data[7:0]; 0 is treated as 1.
- addr 3: background colour, data[2:0].
REQ-024 Handshake: a write is accepted on a cycle with cfg_wr=1 and cfg_ready=1; the data goes to a shadow register.
REQ-025 Config FSM, IDLE state: cfg_ready=1; an accepted write moves the FSM to PENDING.
REQ-026 Config FSM, PENDING state: cfg_ready=0; on the next frame_start the shadow is copied to the active register and the FSM returns to IDLE.
REQ-027 Simultaneous events: if a write is accepted in the same cycle as frame_start, it commits at the following frame_start, not the current one.
REQ-028 Blink timer: a frame counter increments on each frame_start. When it equals period-1 it wraps to 0 and blink_phase toggles.
REQ-029 Period change: a committed period change resets the frame counter to 0; blink_phase is unaffected.
REQ-030 Stage 1 (registered): visible[i] = layer_active[i] & enable[i] & ~(blink[i] & blink_phase). visible, layer_color, x, y and pix_valid are captured.
REQ-031 Stage 2 (registered): a fixed-priority encoder selects the lowest-index visible layer; its colour and index drive color_out and layer_sel, and any_active=1.
REQ-032 No visible layer: color_out = background colour, layer_sel=0, any_active=0.
REQ-033 Latency: exactly 2 cycles from pix_valid to color_valid. The pipeline never stalls and accepts a pixel every cycle.
REQ-034 Invalid pixel: when the pixel in stage 2 is invalid, color_valid=0, color_out=000, any_active=0 and layer_sel=0.
REQ-035 Configuration changes never alter a pixel already in the pipeline until the commit cycle edge; pixels sampled after that edge use the new values.

Reset
REQ-036 Reset values: enable=4'b1111, blink mask=0000, period=DEF_PERIOD, background=000, frame counter=0, blink_phase=0, FSM=IDLE, cfg_ready=1.
REQ-037 On reset, all pipeline valids and all outputs are 0.
REQ-038 Reset asserted during PENDING discards the shadow write.

Structure
REQ-039 A shared package holds the cfg_addr constants (ADDR_ENABLE=0, ADDR_BLINK=1, ADDR_PERIOD=2, ADDR_BG=3), the config FSM state encoding, and the reset defaults.
REQ-040 The frame counter and blink_phase are implemented in one sub-module, blink_timer; the rest of the logic is flat.

Verification
REQ-041 Priority: after reset, layer_active=0101 and colours L0=001, L2=100 -> 2 cycles later color_out=001, layer_sel=0, any_active=1, color_valid=1.
REQ-042 Masking: write addr0=0x0E and pulse frame_start, then layer_active=0101 -> color_out = L2 colour, layer_sel=2.
REQ-043 Background: write addr3=0x05 and commit, then layer_active=0000 -> color_out=101, any_active=0.
REQ-044 Handshake: cfg_wr held with no frame_start -> cfg_ready=0 after acceptance, no config change. A write accepted in the frame_start cycle -> commits only on the next frame_start.
REQ-045 Blink: blink mask=0001, period=2, L0 active -> L0 is hidden in frames 2-3, visible in frames 4-5. Period=0 -> phase toggles every frame.
REQ-046 Reset: assert reset mid-PENDING and mid-stream -> all outputs are 0 the same cycle, cfg_ready=1, and the shadow value is never applied.
